// File: rtl/safebox_pkg.sv
`default_nettype none
// ============================================================================
// safebox_pkg : keypad FSM states, column encodings, key-code mapping
// Rev 1.0
// ============================================================================
package safebox_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      ACCEPT   = 2'd2,
      RELEASE  = 2'd3
   } state_t;

   localparam int c_SCAN_DIV_DEF       = 50000;
   localparam int c_DEBOUNCE_SCANS_DEF = 10;

   localparam logic [3:0] c_COL0 = 4'b1110;
   localparam logic [3:0] c_COL1 = 4'b1101;
   localparam logic [3:0] c_COL2 = 4'b1011;
   localparam logic [3:0] c_COL3 = 4'b0111;

   function automatic logic [3:0] col_drive(input logic [1:0] idx);
      logic [3:0] v;
      case (idx)
         2'd0:    v = c_COL0;
         2'd1:    v = c_COL1;
         2'd2:    v = c_COL2;
         default: v = c_COL3;
      endcase
      return v;
   endfunction

   // Lowest active (low) row wins when several rows are pulled down together.
   function automatic logic [3:0] key_map(input logic [3:0] row_n, input logic [1:0] col_idx);
      logic [1:0] r;
      if (!row_n[0])      r = 2'd0;
      else if (!row_n[1]) r = 2'd1;
      else if (!row_n[2]) r = 2'd2;
      else                r = 2'd3;
      return {r, col_idx};
   endfunction

endpackage
`default_nettype wire

// File: rtl/safebox_toggle_sync.sv
`default_nettype none
// ============================================================================
// safebox_toggle_sync : 2-FF synchronizer with any-edge one-cycle pulse
// Rev 1.0
// ============================================================================
module safebox_toggle_sync (
   input  logic clk,
   input  logic rst,
   input  logic i_din,
   output logic o_pulse
);

   logic r_meta;
   logic r_sync;
   logic r_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
      end else begin
         r_meta <= i_din;
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   assign o_pulse = r_sync ^ r_prev;

endmodule
`default_nettype wire

// File: rtl/keypad_entry.sv
`default_nettype none
// ============================================================================
// keypad_entry : 4x4 keypad scan, debounce and four-digit entry shift register
// Rev 1.0
// ============================================================================
module keypad_entry
   import safebox_pkg::*;
#(
   parameter int SCAN_DIV       = c_SCAN_DIV_DEF,
   parameter int DEBOUNCE_SCANS = c_DEBOUNCE_SCANS_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_clear_toggle,
   input  logic [3:0] i_row,
   output logic [3:0] o_col,
   output logic [3:0] o_p0,
   output logic [3:0] o_p1,
   output logic [3:0] o_p2,
   output logic [3:0] o_p3,
   output logic       o_key_valid,
   output logic [3:0] o_key_code
);

   localparam int              c_SW        = $clog2(SCAN_DIV);
   localparam int              c_CW        = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [c_SW-1:0] c_SLOT_LAST = c_SW'(SCAN_DIV - 1);
   localparam logic [c_CW-1:0] c_CNT_DONE  = c_CW'(DEBOUNCE_SCANS);
   localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);

   logic [3:0]      r_row_meta;
   logic [3:0]      r_row_sync;
   logic [c_SW-1:0] r_slot;
   state_t          r_state,   w_state_nxt;
   logic [1:0]      r_col_idx, w_col_idx_nxt;
   logic [c_CW-1:0] r_cnt,     w_cnt_nxt;
   logic [3:0]      r_pend,    w_pend_nxt;
   logic [c_CW-1:0] w_cnt_inc;
   logic            w_sample;
   logic            w_any_low;
   logic [3:0]      w_code;
   logic            w_clear;
   logic [3:0]      r_p0, r_p1, r_p2, r_p3;
   logic [3:0]      r_key_code;
   logic            r_key_valid;

   safebox_toggle_sync u_clear_sync (
      .clk     (clk),
      .rst     (rst),
      .i_din   (i_clear_toggle),
      .o_pulse (w_clear)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_row_meta <= 4'h0;
         r_row_sync <= 4'h0;
         r_slot     <= '0;
      end else begin
         r_row_meta <= i_row;
         r_row_sync <= r_row_meta;
         r_slot     <= (r_slot == c_SLOT_LAST) ? '0 : r_slot + 1'b1;
      end
   end

   assign w_sample  = (r_slot == c_SLOT_LAST);
   assign w_any_low = ~&r_row_sync;
   assign w_code    = key_map(r_row_sync, r_col_idx);
   assign w_cnt_inc = r_cnt + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= SCAN;
         r_col_idx <= 2'd0;
         r_cnt     <= '0;
         r_pend    <= 4'h0;
      end else begin
         r_state   <= w_state_nxt;
         r_col_idx <= w_col_idx_nxt;
         r_cnt     <= w_cnt_nxt;
         r_pend    <= w_pend_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_col_idx_nxt = r_col_idx;
      w_cnt_nxt     = r_cnt;
      w_pend_nxt    = r_pend;
      case (r_state)
         SCAN: begin
            if (w_sample) begin
               if (w_any_low) begin
                  w_state_nxt = DEBOUNCE;
                  w_pend_nxt  = w_code;
                  w_cnt_nxt   = c_CNT_ONE;
               end else begin
                  w_col_idx_nxt = r_col_idx + 2'd1;
               end
            end
         end
         DEBOUNCE: begin
            // Terminal count is acted on the cycle after it is reached.
            if (r_cnt == c_CNT_DONE) begin
               w_state_nxt = ACCEPT;
            end else if (w_sample) begin
               if (w_any_low && (w_code == r_pend)) begin
                  w_cnt_nxt = w_cnt_inc;
               end else begin
                  w_state_nxt   = SCAN;
                  w_col_idx_nxt = r_col_idx + 2'd1;
                  w_cnt_nxt     = '0;
               end
            end
         end
         ACCEPT: begin
            w_state_nxt = RELEASE;
            w_cnt_nxt   = '0;
         end
         RELEASE: begin
            if (w_sample) begin
               if (w_any_low) begin
                  w_cnt_nxt = '0;
               end else if (w_cnt_inc == c_CNT_DONE) begin
                  w_state_nxt   = SCAN;
                  w_col_idx_nxt = r_col_idx + 2'd1;
                  w_cnt_nxt     = '0;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end
         end
         default: begin
            w_state_nxt = SCAN;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // A clear on the ACCEPT cycle discards the key but leaves key_code alone.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_p0        <= 4'h0;
         r_p1        <= 4'h0;
         r_p2        <= 4'h0;
         r_p3        <= 4'h0;
         r_key_code  <= 4'h0;
         r_key_valid <= 1'b0;
      end else begin
         r_key_valid <= 1'b0;
         if (w_clear) begin
            r_p0 <= 4'h0;
            r_p1 <= 4'h0;
            r_p2 <= 4'h0;
            r_p3 <= 4'h0;
         end else if (r_state == ACCEPT) begin
            r_p3        <= r_p2;
            r_p2        <= r_p1;
            r_p1        <= r_p0;
            r_p0        <= r_pend;
            r_key_code  <= r_pend;
            r_key_valid <= 1'b1;
         end
      end
   end

   assign o_col       = col_drive(r_col_idx);
   assign o_p0        = r_p0;
   assign o_p1        = r_p1;
   assign o_p2        = r_p2;
   assign o_p3        = r_p3;
   assign o_key_code  = r_key_code;
   assign o_key_valid = r_key_valid;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry.sv
`default_nettype none
// ============================================================================
// tb_keypad_entry : directed bench for keypad_entry (SCAN_DIV=4, DEBOUNCE_SCANS=3)
// Rev 1.0
// ============================================================================
module tb_keypad_entry;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear_tg = 1'b0;
   logic [3:0] row;
   logic [3:0] col, p0, p1, p2, p3, kcode;
   logic       kvalid;

   logic       key_down = 1'b0;
   logic [1:0] key_r = 2'd0;
   logic [1:0] key_c = 2'd0;
   logic       ovr_en = 1'b0;
   logic [3:0] ovr_val = 4'hF;

   int n_checks = 0;
   int n_errors = 0;
   int kv_count = 0;

   keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(3)) dut (
      .clk            (clk),
      .rst            (rst),
      .i_clear_toggle (clear_tg),
      .i_row          (row),
      .o_col          (col),
      .o_p0           (p0),
      .o_p1           (p1),
      .o_p2           (p2),
      .o_p3           (p3),
      .o_key_valid    (kvalid),
      .o_key_code     (kcode)
   );

   always #5 clk = ~clk;

   // Matrix model: a held key pulls its row low while its column is driven.
   always_comb begin
      row = 4'hF;
      if (ovr_en)
         row = ovr_val;
      else if (key_down && !col[key_c])
         row = ~(4'b0001 << key_r);
   end

   always @(negedge clk) if (kvalid === 1'b1) kv_count = kv_count + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_kv(input int base, output int cyc);
      cyc = 0;
      while (kv_count <= base && cyc < 200) begin
         tick(1);
         cyc++;
      end
      check("kv_wait", 32'(kv_count > base), 32'd1);
   endtask

   task automatic align_col(input logic [3:0] target);
      logic [3:0] prev;
      int n;
      logic found;
      found = 1'b0;
      n = 0;
      while (!found && n < 40) begin
         prev = col;
         tick(1);
         n++;
         if (col != prev && col == target) found = 1'b1;
      end
      check("align_col", 32'(found), 32'd1);
   endtask

   task automatic press_key(input logic [3:0] code);
      int base, cyc;
      base = kv_count;
      key_r = code[3:2];
      key_c = code[1:0];
      key_down = 1'b1;
      wait_kv(base, cyc);
      tick(4);
      key_down = 1'b0;
      tick(40);
   endtask

   initial begin
      int base, cyc, lat;
      logic [3:0] orig;

      // Reset state
      tick(3);
      check("rst_col", col, 4'b1110);
      check("rst_p0", p0, 4'h0);
      check("rst_p3", p3, 4'h0);
      check("rst_kcode", kcode, 4'h0);
      check("rst_kvalid", kvalid, 1'b0);
      rst = 1'b0;

      // Idle column rotation
      tick(3);  check("col_s0", col, 4'b1110);
      tick(1);  check("col_s1", col, 4'b1101);
      tick(4);  check("col_s2", col, 4'b1011);
      tick(4);  check("col_s3", col, 4'b0111);
      tick(4);  check("col_wrap", col, 4'b1110);
      tick(40);
      check("idle_kv", kv_count, 0);
      check("idle_p0", p0, 4'h0);

      // Key 0 then key 9
      press_key(4'd0);
      check("k0_count", kv_count, 1);
      check("k0_code", kcode, 4'd0);
      check("k0_p0", p0, 4'd0);
      press_key(4'd9);
      check("k9_count", kv_count, 2);
      check("k9_code", kcode, 4'd9);
      check("k9_p0", p0, 4'd9);
      check("k9_p1", p1, 4'd0);

      // Five keys: oldest digits fall off
      for (int k = 1; k <= 5; k++) press_key(4'(k));
      check("five_count", kv_count, 7);
      check("five_p3", p3, 4'd2);
      check("five_p2", p2, 4'd3);
      check("five_p1", p1, 4'd4);
      check("five_p0", p0, 4'd5);

      // Single-sample glitch on row1: column held one slot, then advances
      base = kv_count;
      align_col(4'b1101);
      orig = col;
      ovr_val = 4'b1101;
      ovr_en = 1'b1;
      tick(4);
      ovr_en = 1'b0;
      check("glitch_hold", col, orig);
      tick(4);
      check("glitch_next", col, {orig[2:0], orig[3]});
      tick(20);
      check("glitch_kv", kv_count, base);

      // Long hold then bouncing release
      base = kv_count;
      key_r = 2'd1; key_c = 2'd1; key_down = 1'b1;
      wait_kv(base, cyc);
      tick(200);
      check("hold_kv", kv_count, base + 1);
      for (int i = 0; i < 12; i++) begin
         key_down = (i % 2 == 1);
         tick(4);
      end
      check("bounce_kv", kv_count, base + 1);
      check("bounce_col", col, 4'b1101);
      key_down = 1'b0;
      tick(6);
      check("rel_col_held", col, 4'b1101);
      tick(30);
      check("rel_kv", kv_count, base + 1);
      check("hold_p0", p0, 4'd5);

      // Clear with digits 4,3,2,1
      for (int k = 4; k >= 1; k--) press_key(4'(k));
      check("pre_clr_p3", p3, 4'd4);
      check("pre_clr_p0", p0, 4'd1);
      clear_tg = 1'b1;
      tick(2);
      check("clr_early", p0, 4'd1);
      tick(1);
      check("clr_p0", p0, 4'd0);
      check("clr_p1", p1, 4'd0);
      check("clr_p2", p2, 4'd0);
      check("clr_p3", p3, 4'd0);
      tick(10);

      // Measure press latency on column 3 from a column-0 boundary
      base = kv_count;
      align_col(4'b1110);
      key_r = 2'd1; key_c = 2'd3; key_down = 1'b1;
      lat = 0;
      while (kv_count <= base && lat < 200) begin
         tick(1);
         lat++;
      end
      check("lat_kv", kv_count, base + 1);
      check("lat_p0", p0, 4'd7);
      tick(4);
      key_down = 1'b0;
      tick(40);

      // Clear lands on the ACCEPT cycle of key 11
      base = kv_count;
      align_col(4'b1110);
      key_r = 2'd2; key_c = 2'd3; key_down = 1'b1;
      tick(lat - 4);
      clear_tg = 1'b0;
      tick(3);
      check("coin_kvalid", kvalid, 1'b0);
      check("coin_p0", p0, 4'd0);
      check("coin_kcode", kcode, 4'd7);
      tick(4);
      key_down = 1'b0;
      tick(40);
      check("coin_kv", kv_count, base);
      check("coin_p0_after", p0, 4'd0);

      // Reset during debounce, key re-detected afterwards
      align_col(4'b1011);
      key_r = 2'd1; key_c = 2'd2; key_down = 1'b1;
      tick(4);
      check("deb_col_held", col, 4'b1011);
      rst = 1'b1;
      #1;
      check("arst_col", col, 4'b1110);
      check("arst_kcode", kcode, 4'h0);
      check("arst_kvalid", kvalid, 1'b0);
      tick(2);
      rst = 1'b0;
      base = kv_count;
      wait_kv(base, cyc);
      check("post_rst_code", kcode, 4'd6);
      check("post_rst_p0", p0, 4'd6);
      tick(4);
      key_down = 1'b0;
      tick(40);
      check("post_rst_kv", kv_count, base + 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
